// File: rtl/result_frame_accum.sv
// Frame accumulator behind the 18-bit datapath stage.
// Buffers results in a small FIFO and emits per-frame signed sum and max.
module result_frame_accum #(
  parameter int DATA_W     = 18,
  parameter int FRAME_LEN  = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int ACC_W     = DATA_W + $clog2(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [DATA_W-1:0] out_max
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(FRAME_LEN);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              alive_q;
  logic [CW-1:0]     count_q;
  logic [ACC_W-1:0]  acc_q;
  logic [DATA_W-1:0] max_q;

  logic              full, empty, push, pop, last, hs;
  logic [DATA_W-1:0] head, max_nxt;
  logic [ACC_W-1:0]  head_x;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign in_ready = alive_q && !full && !flush;
  assign push     = in_valid && in_ready;
  assign hs       = out_valid && out_ready;

  assign head    = mem[rd_ptr[AW-1:0]];
  assign head_x  = {{(ACC_W-DATA_W){head[DATA_W-1]}}, head};
  assign last    = (count_q == CW'(FRAME_LEN-1));
  assign max_nxt = ((count_q == '0) || ($signed(head) > $signed(max_q)))
                   ? head : max_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ACCUM;
    end else begin
      unique case (state_q)
        ACCUM: if (pop && last) state_d = HOLD;
        HOLD:  if (hs)          state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  always_comb begin
    pop = 1'b0;
    if (!flush && state_q == ACCUM && !empty) pop = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      acc_q     <= '0;
      max_q     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_max   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      alive_q <= 1'b1;
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count_q   <= '0;
        acc_q     <= '0;
        max_q     <= '0;
        out_valid <= 1'b0;
      end else begin
        if (push) begin
          mem[wr_ptr[AW-1:0]] <= in_data;
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          if (last) begin
            out_sum   <= acc_q + head_x;
            out_max   <= max_nxt;
            out_valid <= 1'b1;
            acc_q     <= '0;
            count_q   <= '0;
          end else begin
            acc_q   <= acc_q + head_x;
            max_q   <= max_nxt;
            count_q <= count_q + 1'b1;
          end
        end
        if (state_q == HOLD && hs) out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_result_frame_accum.sv
// Scoreboard bench for result_frame_accum.
// Directed frames queue expected results; a monitor checks handshakes.
module tb_result_frame_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [17:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [20:0] out_sum;
  logic [17:0] out_max;

  int checks = 0;
  int errors = 0;
  logic [38:0] exp_q [$];

  result_frame_accum dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_max(out_max)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame: got sum %h max %h expected none",
                 out_sum, out_max);
      end else begin
        logic [38:0] e;
        e = exp_q.pop_front();
        if (out_sum !== e[38:18] || out_max !== e[17:0]) begin
          errors++;
          $display("FAIL frame: got sum %h max %h expected sum %h max %h",
                   out_sum, out_max, e[38:18], e[17:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [17:0] d);
    logic rdy;
    int   n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      @(negedge clk);
      rdy = in_ready;
      tick();
      n++;
    end while (!rdy && n < 50);
    if (!rdy) chk("send_timeout", 32'(rdy), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic expect_frame(input logic [20:0] s, input logic [17:0] m);
    exp_q.push_back({s, m});
  endtask

  initial begin
    int acc_n;
    logic [17:0] mix [8];

    // Reset release and the basic 1..8 frame.
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", 32'(in_ready), 32'd0);
    chk("out_valid_reset", 32'(out_valid), 32'd0);
    chk("out_sum_reset", 32'(out_sum), 32'd0);
    out_ready = 1'b1;
    expect_frame(21'h000024, 18'd8);
    for (int i = 1; i <= 8; i++) begin
      send(18'(i));
      if (i == 8) chk("latency_not_yet", 32'(out_valid), 32'd0);
    end
    tick();
    chk("latency_valid", 32'(out_valid), 32'd1);
    repeat (3) tick();

    // Negative and extreme frames.
    expect_frame(21'h1FFFF8, 18'h3FFFF);
    for (int i = 0; i < 8; i++) send(18'h3FFFF);
    expect_frame(21'h0FFFF8, 18'h1FFFF);
    for (int i = 0; i < 8; i++) send(18'h1FFFF);
    expect_frame(21'h100000, 18'h20000);
    for (int i = 0; i < 8; i++) send(18'h20000);
    mix = '{18'h20000, 18'h1FFFF, 18'h0, 18'h0,
            18'h0, 18'h0, 18'h0, 18'h0};
    expect_frame(21'h1FFFFF, 18'h1FFFF);
    for (int i = 0; i < 8; i++) send(mix[i]);
    repeat (6) tick();
    chk("drain_extremes", 32'(exp_q.size()), 32'd0);

    // Backpressure: 12 accepted, then stall while result is held.
    out_ready = 1'b0;
    acc_n = 0;
    in_valid = 1'b1;
    in_data = 18'd1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (in_ready) acc_n++;
      tick();
    end
    chk("bp_accepted", 32'(acc_n), 32'd12);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_valid_held", 32'(out_valid), 32'd1);
    chk("bp_sum_held", 32'(out_sum), 32'd8);
    expect_frame(21'd8, 18'd1);
    expect_frame(21'd8, 18'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_valid_cleared", 32'(out_valid), 32'd0);
    chk("bp_no_pop_on_hs", 32'(in_ready), 32'd0);
    @(negedge clk);
    if (in_ready) acc_n++;
    tick();
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);
    for (int c = 0; c < 40 && acc_n < 16; c++) begin
      @(negedge clk);
      if (in_ready) acc_n++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_total", 32'(acc_n), 32'd16);
    out_ready = 1'b1;
    repeat (12) tick();
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Flush abandons a partial frame.
    for (int i = 0; i < 3; i++) send(18'd100);
    in_valid = 1'b1;
    in_data = 18'd100;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    repeat (4) tick();
    chk("flush_no_valid", 32'(out_valid), 32'd0);
    expect_frame(21'd16, 18'd2);
    for (int i = 0; i < 8; i++) send(18'd2);
    repeat (4) tick();
    chk("flush_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset while a result is held.
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(18'(i));
    repeat (3) tick();
    chk("hold_before_reset", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    expect_frame(21'h000024, 18'd8);
    for (int i = 1; i <= 8; i++) send(18'(i));
    repeat (4) tick();
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
